// File: rtl/shufflenetv2_mul_share_arb.sv
// shufflenetv2_mul_share_arb: round-robin arbiter sharing one pipelined 13x11 multiplier among four requesters
module shufflenetv2_mul_share_arb #(
  parameter int MUL_LAT = 2,
  parameter int NUM_REQ = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [13*NUM_REQ-1:0] req_a,
  input  logic [11*NUM_REQ-1:0] req_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [23:0]           out_p,
  output logic [1:0]            out_id,
  output logic [15:0]           issue_cnt,
  output logic                  idle
);
  logic [MUL_LAT-1:0] sv;
  logic [23:0] sp [MUL_LAT];
  logic [1:0] sid [MUL_LAT];
  logic [1:0] rr_ptr, off, g;
  logic [2:0] rot;
  logic adv, xfer;
  logic [23:0] prod;
  assign adv = !sv[MUL_LAT-1] || out_ready;
  assign rot = 3'({req_valid, req_valid} >> rr_ptr);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign g = rr_ptr + off;
  assign xfer = adv && |req_valid && !ap_rst;
  assign req_ready = xfer ? {{(NUM_REQ-1){1'b0}}, 1'b1} << g : '0;
  assign prod = 24'(req_a[13*g +: 13]) * 24'(req_b[11*g +: 11]);
  assign out_valid = sv[MUL_LAT-1];
  assign out_p = out_valid ? sp[MUL_LAT-1] : '0;
  assign out_id = out_valid ? sid[MUL_LAT-1] : '0;
  assign idle = !(|sv) && !(|req_valid);
  // stage valids, round-robin pointer and issue counter; everything holds while the output stalls
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      sv <= '0;
      rr_ptr <= '0;
      issue_cnt <= '0;
    end else if (adv) begin
      sv <= MUL_LAT'({sv, xfer});
      if (xfer) begin
        rr_ptr <= g + 2'd1;
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  // product and id payload; contents behind a cleared valid are don't-care
  always_ff @(posedge ap_clk)
    if (adv) begin
      sp[0] <= prod;
      sid[0] <= g;
      for (int i = 1; i < MUL_LAT; i++) begin
        sp[i] <= sp[i-1];
        sid[i] <= sid[i-1];
      end
    end
endmodule

// File: tb/tb_shufflenetv2_mul_share_arb.sv
// tb_shufflenetv2_mul_share_arb: random and directed checks against an in-flight queue model
module tb_shufflenetv2_mul_share_arb;
  localparam int L = 2;
  logic ap_clk = 0, ap_rst = 1, out_ready = 1;
  logic [3:0] req_valid = 0, req_ready;
  logic [51:0] req_a = 0;
  logic [43:0] req_b = 0;
  logic out_valid, idle;
  logic [23:0] out_p;
  logic [1:0] out_id;
  logic [15:0] issue_cnt;
  int checks = 0, failures = 0;
  typedef struct {logic [1:0] id; logic [23:0] p; int pos;} item_t;
  item_t q[$];
  int ptr = 0;
  logic [15:0] cnt = 0;
  always #5 ap_clk = ~ap_clk;
  shufflenetv2_mul_share_arb #(.MUL_LAT(L), .NUM_REQ(4)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_id(out_id), .issue_cnt(issue_cnt), .idle(idle));
  function automatic bit m_ov();
    return q.size() > 0 && q[0].pos == L - 1;
  endfunction
  function automatic logic [3:0] m_rdy();
    if (ap_rst || (m_ov() && !out_ready)) return 4'd0;
    for (int k = 0; k < 4; k++) if (req_valid[(ptr + k) % 4]) return 4'(1 << ((ptr + k) % 4));
    return 4'd0;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask
  task automatic compare();
    chk("req_ready", 32'(req_ready), 32'(m_rdy()));
    chk("out_valid", 32'(out_valid), 32'(m_ov()));
    chk("out_p", 32'(out_p), m_ov() ? 32'(q[0].p) : 0);
    chk("out_id", 32'(out_id), m_ov() ? 32'(q[0].id) : 0);
    chk("issue_cnt", 32'(issue_cnt), 32'(cnt));
    chk("idle", 32'(idle), 32'(q.size() == 0 && req_valid == 0));
  endtask
  task automatic step();
    logic [3:0] r;
    bit ov;
    int g;
    @(negedge ap_clk);
    compare();
    @(posedge ap_clk);
    r = m_rdy();
    ov = m_ov();
    if (ap_rst) begin
      q.delete(); ptr = 0; cnt = 0;
    end else if (!ov || out_ready) begin
      if (ov) void'(q.pop_front());
      foreach (q[i]) q[i].pos++;
      if (r != 0) begin
        g = 0;
        for (int k = 0; k < 4; k++) if (r[k]) g = k;
        q.push_back('{id: 2'(g), p: 24'(req_a[13*g +: 13]) * 24'(req_b[11*g +: 11]), pos: 0});
        ptr = (g + 1) % 4;
        cnt++;
      end
    end
    #1;
  endtask
  task automatic do_rst();
    ap_rst = 1;
    q.delete(); ptr = 0; cnt = 0;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 0);
    chk("rst_async_req_ready", 32'(req_ready), 0);
    step();
    ap_rst = 0;
  endtask
  task automatic randomize_ops();
    req_a = {20'($urandom), $urandom};
    req_b = {12'($urandom), $urandom};
  endtask
  initial begin
    logic [23:0] hp;
    logic [1:0] hid;
    int n;
    step(); step();
    chk("reset_idle", 32'(idle), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    ap_rst = 0;
    req_valid = 4'b0001; req_a[12:0] = 13'd100; req_b[10:0] = 11'd7;
    #1 chk("single_req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 0;
    chk("single_cnt", 32'(issue_cnt), 1);
    chk("single_not_yet", 32'(out_valid), 0);
    step();
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_p", 32'(out_p), 700);
    chk("single_out_id", 32'(out_id), 0);
    req_valid = 4'b0010; req_a[25:13] = 13'd8191; req_b[21:11] = 11'd2047;
    step();
    req_valid = 0;
    step();
    chk("max_out_p", 32'(out_p), 32'hFFD801);
    chk("max_out_id", 32'(out_id), 1);
    step();
    randomize_ops();
    req_valid = 4'b1111;
    step(); step();
    do_rst();
    #1 chk("post_rst_grant", 32'(req_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      step();
      if (i >= 1) chk("rr_out_id", 32'(out_id), 32'(i - 1));
      if (i == 3) chk("rr_cnt", 32'(issue_cnt), 4);
    end
    out_ready = 0;
    hp = q[0].p;
    hid = q[0].id;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_req_ready", 32'(req_ready), 0);
      chk("stall_out_p", 32'(out_p), 32'(hp));
      chk("stall_out_id", 32'(out_id), 32'(hid));
      step();
    end
    out_ready = 1;
    req_valid = 0;
    n = 0;
    while (q.size() > 0 && n < 10) begin step(); n++; end
    chk("drain_idle", 32'(idle), 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) do_rst();
      req_valid = 4'($urandom);
      randomize_ops();
      out_ready = $urandom_range(3) != 0;
      step();
    end
    do_rst();
    req_valid = 4'b1111;
    out_ready = 1;
    for (int i = 0; i < 65536; i++) step();
    chk("cnt_wrap", 32'(issue_cnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
